// File: rtl/interrupter_sched.sv
// Interrupter scheduler for the DRSSTC controller.
// Validates parameter sets from the UART decoder, stages them in a shadow
// bank and commits them to the active bank only at pulse boundaries, then
// generates the burst-modulated interrupter enable for the gate driver.
// Optional feature macro: INTERRUPTER_DUTY_LIMIT_EN (rejects sets whose
// duty exceeds 12.5%, i.e. on_time*8 > period).
module interrupter_sched #(
  parameter int unsigned PAR_W    = 16,
  parameter int unsigned TICK_DIV = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [PAR_W-1:0] cfg_period,
  input  logic [PAR_W-1:0] cfg_on_time,
  input  logic [PAR_W-1:0] cfg_burst_len,
  input  logic [PAR_W-1:0] cfg_burst_gap,
  input  logic             enable,
  input  logic             fault,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             intr_out,
  output logic             busy,
  output logic             fault_latched
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
`ifdef INTERRUPTER_DUTY_LIMIT_EN
  localparam int unsigned DUTY_W = PAR_W + 3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ON    = 3'd1,
    ST_OFF   = 3'd2,
    ST_GAP   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  logic [PAR_W-1:0] phase_q, phase_d;
  logic [PAR_W-1:0] pulse_q, pulse_d;

  logic [PAR_W-1:0] shd_period_q, shd_on_q, shd_burst_q, shd_gap_q;
  logic [PAR_W-1:0] act_on_q, act_off_q, act_burst_q, act_gap_q;
  logic             cfg_loaded_q;
  logic             pending_q, pending_d;

  logic             set_ok;
  logic             accept;
  logic             take;
  logic             reject;
  logic             commit;
  logic             last_pulse;

  logic             intr_q;
  logic             busy_q;
  logic             fault_latched_q;
  logic             cfg_ready_q;
  logic             cfg_err_q;

  // Free-running timebase prescaler; tick marks its terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign tick = (pre_q == PRE_MAX);

  // Parameter set validation
  always_comb begin
    set_ok = (cfg_period != '0) && (cfg_on_time != '0) &&
             (cfg_on_time < cfg_period) && (cfg_burst_len != '0);
`ifdef INTERRUPTER_DUTY_LIMIT_EN
    if ({cfg_on_time, 3'b000} > DUTY_W'(cfg_period)) begin
      set_ok = 1'b0;
    end
`endif
  end

  assign accept     = cfg_valid & cfg_ready_q;
  assign take       = accept & set_ok;
  assign reject     = accept & ~set_ok;
  assign last_pulse = (pulse_q >= act_burst_q);
  assign pending_d  = take ? 1'b1 : (commit ? 1'b0 : pending_q);

  // Shadow bank captures every accepted set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_period_q <= '0;
      shd_on_q     <= '0;
      shd_burst_q  <= '0;
      shd_gap_q    <= '0;
    end else if (take) begin
      shd_period_q <= cfg_period;
      shd_on_q     <= cfg_on_time;
      shd_burst_q  <= cfg_burst_len;
      shd_gap_q    <= cfg_burst_gap;
    end
  end

  // Active bank; off-time is precomputed here so the phase logic never subtracts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_on_q     <= '0;
      act_off_q    <= '0;
      act_burst_q  <= '0;
      act_gap_q    <= '0;
      cfg_loaded_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (commit) begin
        act_on_q     <= shd_on_q;
        act_off_q    <= shd_period_q - shd_on_q;
        act_burst_q  <= shd_burst_q;
        act_gap_q    <= shd_gap_q;
        cfg_loaded_q <= 1'b1;
      end
    end
  end

  // Scheduler state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic: fault > enable drop > phase end > commit
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    commit  = 1'b0;
    if (fault) begin
      state_d = ST_FAULT;
      phase_d = '0;
      pulse_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tick && enable && cfg_loaded_q) begin
            state_d = ST_ON;
            phase_d = PAR_W'(1);
            pulse_d = PAR_W'(1);
          end
        end
        ST_ON: begin
          if (tick) begin
            if (phase_q == act_on_q) begin
              if (enable) begin
                state_d = ST_OFF;
                phase_d = PAR_W'(1);
              end else begin
                state_d = ST_IDLE;
                phase_d = '0;
                pulse_d = '0;
              end
            end else begin
              phase_d = phase_q + PAR_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (!enable) begin
              state_d = ST_IDLE;
              phase_d = '0;
              pulse_d = '0;
            end else if (phase_q == act_off_q) begin
              commit  = pending_q;
              phase_d = PAR_W'(1);
              if (last_pulse && (act_gap_q != '0)) begin
                state_d = ST_GAP;
              end else begin
                state_d = ST_ON;
                pulse_d = last_pulse ? PAR_W'(1) : pulse_q + PAR_W'(1);
              end
            end else begin
              phase_d = phase_q + PAR_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (!enable) begin
              state_d = ST_IDLE;
              phase_d = '0;
              pulse_d = '0;
            end else if (phase_q == act_gap_q) begin
              commit  = pending_q;
              state_d = ST_ON;
              phase_d = PAR_W'(1);
              pulse_d = PAR_W'(1);
            end else begin
              phase_d = phase_q + PAR_W'(1);
            end
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          pulse_d = '0;
        end
      endcase
    end
    // A parked scheduler has no pulse in flight, so a staged set may land at once
    if (pending_q && ((state_q == ST_IDLE) || (state_q == ST_FAULT))) begin
      commit = 1'b1;
    end
  end

  // Registered status and drive outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q          <= 1'b0;
      busy_q          <= 1'b0;
      fault_latched_q <= 1'b0;
      cfg_ready_q     <= 1'b1;
      cfg_err_q       <= 1'b0;
    end else begin
      intr_q          <= (state_d == ST_ON);
      busy_q          <= (state_d != ST_IDLE);
      fault_latched_q <= (state_d == ST_FAULT);
      cfg_ready_q     <= ~pending_d;
      cfg_err_q       <= reject;
    end
  end

  // Fault kills the drive without waiting for a clock edge
  assign intr_out      = intr_q & ~fault;
  assign busy          = busy_q;
  assign fault_latched = fault_latched_q;
  assign cfg_ready     = cfg_ready_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_interrupter_sched.sv
// Self-checking bench for interrupter_sched with a one-clock tick.
// Expected intr_out run lengths are queued as stimulus is applied and
// compared against measured high/low runs.
module tb_interrupter_sched;

  localparam int unsigned PAR_W = 16;
  localparam int RUN_LIMIT = 200;

  typedef struct {
    logic lvl;
    int   len;
  } run_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic [PAR_W-1:0] cfg_period, cfg_on_time, cfg_burst_len, cfg_burst_gap;
  logic             enable, fault;
  logic             cfg_ready, cfg_err, intr_out, busy, fault_latched;

  int n_cmp = 0;
  int n_err = 0;
  run_t exp_q[$];

  interrupter_sched #(.PAR_W(PAR_W), .TICK_DIV(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_period    (cfg_period),
    .cfg_on_time   (cfg_on_time),
    .cfg_burst_len (cfg_burst_len),
    .cfg_burst_gap (cfg_burst_gap),
    .enable        (enable),
    .fault         (fault),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .intr_out      (intr_out),
    .busy          (busy),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_cfg(input int p, input int o, input int b, input int g);
    cfg_period    = PAR_W'(p);
    cfg_on_time   = PAR_W'(o);
    cfg_burst_len = PAR_W'(b);
    cfg_burst_gap = PAR_W'(g);
    cfg_valid     = 1'b1;
  endtask

  // Length of the intr_out run that starts at the current falling edge
  task automatic measure_run(output logic lvl, output int len);
    lvl = intr_out;
    len = 0;
    while (intr_out === lvl && len < RUN_LIMIT) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; enable = 1'b0; fault = 1'b0;
    cfg_period = '0; cfg_on_time = '0; cfg_burst_len = '0; cfg_burst_gap = '0;
    #12;
    n_cmp++; if (intr_out !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b want 0", intr_out); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", cfg_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (fault_latched !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", fault_latched); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || intr_out !== 1'b0) begin n_err++; $display("FAIL idle_unloaded busy=%b intr=%b want 0/0", busy, intr_out); end
  endtask

  task automatic test_burst();
    logic l; int n; run_t e;
    drive_cfg(10, 3, 2, 5);
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b1, 3}); exp_q.push_back('{1'b0, 7});
      exp_q.push_back('{1'b1, 3}); exp_q.push_back('{1'b0, 12});
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL burst_ready_pend got %b want 0", cfg_ready); end
    @(negedge clk);
    n_cmp++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL burst_commit ready=%b busy=%b want 1/0", cfg_ready, busy); end
    @(negedge clk);
    n_cmp++; if (intr_out !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL burst_start intr=%b busy=%b want 1/1", intr_out, busy); end
    for (int i = 0; i < 8; i++) begin
      measure_run(l, n);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL burst_run%0d scoreboard empty got lvl=%b len=%0d", i, l, n);
      end else begin
        e = exp_q.pop_front();
        if (l !== e.lvl || n !== e.len) begin
          n_err++; $display("FAIL burst_run%0d got lvl=%b len=%0d want lvl=%b len=%0d", i, l, n, e.lvl, e.len);
        end
      end
    end
  endtask

  task automatic test_invalid();
    int bad[5][4] = '{'{10, 10, 2, 5}, '{0, 3, 2, 5}, '{10, 0, 2, 5},
                      '{10, 3, 0, 5}, '{10, 12, 2, 5}};
    exp_q.push_back('{1'b1, 3}); exp_q.push_back('{1'b0, 7});
    exp_q.push_back('{1'b1, 3}); exp_q.push_back('{1'b0, 12});
    fork
      begin
        logic l; int n; run_t e;
        for (int i = 0; i < 4; i++) begin
          measure_run(l, n);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL inv_run%0d scoreboard empty got lvl=%b len=%0d", i, l, n);
          end else begin
            e = exp_q.pop_front();
            if (l !== e.lvl || n !== e.len) begin
              n_err++; $display("FAIL inv_run%0d got lvl=%b len=%0d want lvl=%b len=%0d", i, l, n, e.lvl, e.len);
            end
          end
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          drive_cfg(bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
          @(negedge clk);
          cfg_valid = 1'b0;
          n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL inv_err%0d got %b want 1", i, cfg_err); end
          @(negedge clk);
          n_cmp++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL inv_clear%0d err=%b ready=%b want 0/1", i, cfg_err, cfg_ready); end
        end
      end
    join
  endtask

  task automatic test_commit_mid_on();
    exp_q.push_back('{1'b1, 3}); exp_q.push_back('{1'b0, 7});
    exp_q.push_back('{1'b1, 4}); exp_q.push_back('{1'b0, 21});
    exp_q.push_back('{1'b1, 4}); exp_q.push_back('{1'b0, 16});
    exp_q.push_back('{1'b1, 4}); exp_q.push_back('{1'b0, 21});
    fork
      begin
        logic l; int n; run_t e;
        for (int i = 0; i < 8; i++) begin
          measure_run(l, n);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL cmt_run%0d scoreboard empty got lvl=%b len=%0d", i, l, n);
          end else begin
            e = exp_q.pop_front();
            if (l !== e.lvl || n !== e.len) begin
              n_err++; $display("FAIL cmt_run%0d got lvl=%b len=%0d want lvl=%b len=%0d", i, l, n, e.lvl, e.len);
            end
          end
          if (i == 0) begin
            n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL cmt_ready_off got %b want 0", cfg_ready); end
          end
          if (i == 1) begin
            n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL cmt_ready_on got %b want 1", cfg_ready); end
          end
        end
      end
      begin
        @(negedge clk);
        drive_cfg(20, 4, 2, 5);
        @(negedge clk);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL cmt_ready_pend got %b want 0", cfg_ready); end
        drive_cfg(10, 0, 2, 5);
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cmt_ignored_err got %b want 0", cfg_err); end
      end
    join
  endtask

  task automatic test_fault();
    @(negedge clk);
    fault = 1'b1;
    #1;
    n_cmp++; if (intr_out !== 1'b0) begin n_err++; $display("FAIL flt_comb intr got %b want 0", intr_out); end
    @(negedge clk);
    n_cmp++; if (fault_latched !== 1'b1 || intr_out !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL flt_latch fl=%b intr=%b busy=%b want 1/0/1", fault_latched, intr_out, busy); end
    fault = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (fault_latched !== 1'b1 || intr_out !== 1'b0) begin
      n_err++; $display("FAIL flt_rearm fl=%b intr=%b want 1/0", fault_latched, intr_out); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (fault_latched !== 1'b0 || busy !== 1'b0 || intr_out !== 1'b0) begin
      n_err++; $display("FAIL flt_exit fl=%b busy=%b intr=%b want 0/0/0", fault_latched, busy, intr_out); end
  endtask

  task automatic test_enable_drop();
    logic l; int n; int w; run_t e;
    drive_cfg(10, 3, 2, 5);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back('{1'b1, 3});
    enable = 1'b1;
    w = 0;
    while (intr_out !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    n_cmp++; if (intr_out !== 1'b1) begin n_err++; $display("FAIL drop_start intr got %b want 1 after %0d cycles", intr_out, w); end
    @(negedge clk);
    enable = 1'b0;
    measure_run(l, n);
    n = n + 1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL drop_run scoreboard empty got lvl=%b len=%0d", l, n);
    end else begin
      e = exp_q.pop_front();
      if (l !== e.lvl || n !== e.len) begin
        n_err++; $display("FAIL drop_run got lvl=%b len=%0d want lvl=%b len=%0d", l, n, e.lvl, e.len);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle busy got %b want 0", busy); end
    repeat (12) @(negedge clk);
    n_cmp++; if (intr_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL drop_stay intr=%b busy=%b want 0/0", intr_out, busy); end
  endtask

  task automatic test_duty_limit();
    logic want_err;
`ifdef INTERRUPTER_DUTY_LIMIT_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    drive_cfg(16, 3, 1, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== want_err || cfg_ready !== want_err) begin
      n_err++; $display("FAIL duty_16_3 err=%b ready=%b want %b/%b", cfg_err, cfg_ready, want_err, want_err); end
    repeat (3) @(negedge clk);
    drive_cfg(24, 3, 1, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL duty_24_3 err=%b ready=%b want 0/0", cfg_err, cfg_ready); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_burst();
    test_invalid();
    test_commit_mid_on();
    test_fault();
    test_enable_drop();
    test_duty_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupter_sched.md
Name: interrupter_sched

Overview:
- Interrupter scheduler for the DRSSTC controller.
- Takes parameter words decoded by the UART receiver, validates them, and commits them into an active bank at safe boundaries.
- Generates the burst-modulated interrupter enable (`intr_out`) that gates the resonant driver.
- Sits between the UART parameter shift register and the gate-drive logic.

Parameters:
- PAR_W, 16: width of each timing parameter word.
- TICK_DIV, 50: clk cycles per timing tick (1 us at 50 MHz). Must be ≥ 1.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- cfg_valid  in  1: one-cycle strobe; a complete parameter set is present on the cfg_* inputs.
- cfg_period  in  PAR_W: pulse period in ticks.
- cfg_on_time  in  PAR_W: on-time per pulse in ticks.
- cfg_burst_len  in  PAR_W: pulses per burst.
- cfg_burst_gap  in  PAR_W: off-gap after a burst in ticks; 0 means continuous.
- enable  in  1: run request.
- fault  in  1: overcurrent/fault input, active-high.
- cfg_ready  out  1: scheduler can accept a new set.
- cfg_err  out  1: one-cycle pulse when a set is rejected.
- intr_out  out  1: interrupter enable to the driver.
- busy  out  1: state is not IDLE.
- fault_latched  out  1: scheduler is in FAULT.

Behaviour:
- Reset values (async on rst_n low):
  - intr_out=0, cfg_err=0, busy=0, fault_latched=0, cfg_ready=1.
  - Active bank cleared, cfg_loaded=0, pending=0.
  - Prescaler=0, all counters=0, state=IDLE.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1.
  - tick=1 when it equals TICK_DIV-1, then wraps to 0.
  - All phase transitions happen only on tick cycles.
- Validation, on cfg_valid & cfg_ready:
  - Valid iff period≠0, on_time≠0, on_time<period, burst_len≠0.
  - Invalid set: cfg_err=1 the next cycle; active and pending banks unchanged.
  - cfg_valid while cfg_ready=0 is ignored, with no cfg_err.
- Commit:
  - Valid set goes to the shadow bank and sets pending=1; cfg_ready=0 while pending.
  - In IDLE/FAULT: shadow is copied to active the next cycle.
  - Otherwise: copied on the tick that ends an OFF or GAP phase, before the next ON begins.
  - On copy: pending clears, cfg_loaded=1.
  - Bursts never mix old and new parameters within one pulse.
- States: IDLE, ON, OFF, GAP, FAULT.
  - IDLE → ON: on a tick with enable & cfg_loaded & !fault. Pulse counter=1, phase counter=1.
  - ON (intr_out=1): when phase counter = on_time on a tick → OFF, phase counter=1.
  - OFF:
    - When phase counter = period−on_time on a tick:
      - If pulse counter = burst_len and burst_gap≠0 → GAP, phase counter=1.
      - Otherwise → ON; pulse counter increments, or restarts at 1 after burst_len.
  - GAP: when phase counter = burst_gap on a tick → ON, pulse counter=1.
  - enable low:
    - In ON, the current pulse completes (no truncation), then IDLE instead of OFF.
    - In OFF/GAP → IDLE at the next tick.
  - FAULT:
    - Entered from any state the cycle after fault=1.
    - intr_out is combinationally forced 0 while fault=1; it is never high in FAULT.
    - fault_latched=1 in FAULT.
    - Exit to IDLE only when fault=0 and enable=0 (re-arm required).
- Priority on simultaneous events: fault > enable drop > phase end > commit.
- Arithmetic: counters are PAR_W bits; period−on_time is computed once at commit (no underflow, since validated).
- busy = (state≠IDLE).

Optional Feature:
- Macro: INTERRUPTER_DUTY_LIMIT_EN.
- Defined: validation additionally rejects sets with on_time×8 > period (duty > 12.5%), using a PAR_W+3-bit compare; rejection pulses cfg_err as usual.
- Undefined: only the base rules apply.

Test Plan (TICK_DIV=1):
- Load period=10, on=3, burst_len=2, gap=5, enable=1 → intr_out high 3 / low 7 / high 3 / low 7 / low 5 (gap), repeating; busy=1.
- cfg on_time=10, period=10 → cfg_err pulse 1 cycle; active bank unchanged; output timing unchanged.
- New set period=20, on=4 sent mid-ON → cfg_ready=0 until end of current OFF; the next pulse is exactly 4 ticks.
- fault=1 mid-ON → intr_out=0 the same cycle, fault_latched=1 the next cycle; fault=0 with enable=1 stays in FAULT; enable=0 → IDLE.
- enable dropped at the 2nd tick of a 3-tick ON → pulse completes to 3 ticks, then IDLE, intr_out=0.
- With INTERRUPTER_DUTY_LIMIT_EN: period=16, on=3 → cfg_err; period=24, on=3 → accepted.
